rocketcpu_timer_sched: RTL and testbench
========================================

ROCKETCPU_TIMER_SCHED -- requirements
Module: rocketcpu_timer_sched

Interface
REQ-001 Parameter WIDTH, default 16, width of the free-running time counter (8..32).
REQ-002 Parameter DIVIDER, default 0, the visible timebase is mtime[WIDTH-1:DIVIDER]; slice width S = WIDTH-DIVIDER.
REQ-003 Parameter CHANNELS, default 4, number of virtual timer channels (power of two, 2..8).
REQ-004 i_wb_clk  in  1  sole clock; all state on rising edge.
REQ-005 i_wb_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_wb_adr  in  5  word address of register.
REQ-007 i_wb_dat  in  32  write data.
REQ-008 i_wb_we  in  1  write enable, qualified by i_wb_cyc.
REQ-009 i_wb_cyc  in  1  bus cycle request.
REQ-010 o_wb_ack  out  1  single-cycle acknowledge.
REQ-011 o_wb_rdt  out  32  read data, valid with o_wb_ack, zero otherwise.
REQ-012 o_irq  out  1  level interrupt, high while any enabled channel is pending.

Function
REQ-013 Register map (word addr): 0 TIME (RO, slice zero-extended); 1 PENDING (W1C); 2 ENABLE (RW); 3 ACTIVE (RO: bit 31 valid, bits 2:0 lowest-index enabled pending channel); 4..4+CHANNELS-1 CMP[k] (RW, S bits); unmapped reads return 0, writes ignored.
REQ-014 mtime increments by 1 every cycle, wraps modulo 2^WIDTH.
REQ-015 o_wb_ack asserts the cycle after i_wb_cyc is sampled high with o_wb_ack low; deasserts the following cycle; one access per ack.
REQ-016 Writing CMP[k] loads the compare value and sets armed[k]; reading returns the stored value.
REQ-017 Scanner: pointer p cycles 0..CHANNELS-1, one channel per cycle, wrapping to 0.
REQ-018 At channel p: expired when armed[p] and MSB of (slice - CMP[p]) mod 2^S is 0 (wrap-safe; deadline up to 2^(S-1)-1 ticks ahead).
REQ-019 On expiry: pending[p] set next cycle; armed[p] cleared (one-shot mode).
REQ-020 Detection latency after slice reaches CMP: at most CHANNELS cycles to pending; o_irq registered, one further cycle.
REQ-021 o_irq = registered OR of (pending & ENABLE); disabled channels still set pending.
REQ-022 PENDING write: each 1 bit clears that pending bit; if expiry sets the same bit in the same cycle, set wins.
REQ-023 CMP[k] write in the cycle scanner evaluates k: write wins, channel re-armed, no pending set that cycle.
REQ-024 Unarmed channels never set pending, regardless of compare value.

Reset
REQ-025 On i_wb_rst: mtime, p, pending, armed, ENABLE, CMP[*] = 0; o_irq = 0, o_wb_ack = 0, o_wb_rdt = 0.
REQ-026 Reset asserted mid-access aborts the access; no ack issued for it.

Configuration
REQ-027 Macro ROCKETCPU_TIMER_SCHED_PERIODIC_EN defined: adds PERIOD[k] registers at word 4+CHANNELS+k (RW, S bits, reset 0); on expiry with PERIOD[k] nonzero, CMP[k] += PERIOD[k] (mod 2^S) and armed[k] stays set; PERIOD[k]=0 behaves one-shot.
REQ-028 Macro undefined: no PERIOD storage, those addresses unmapped, all channels one-shot.

Structure
REQ-029 Shared package rocketcpu_timer_pkg holds register word offsets and the ACTIVE valid-bit position.
REQ-030 One sub-module rocketcpu_timer_cmp: combinational wrap-safe "slice reached compare" test, parameterised on S; instantiated once, fed by scanner mux.

Verification
REQ-031 Reset, WIDTH=16, CHANNELS=4: write CMP[2]=100, ENABLE=4 -> PENDING=0x4 by slice 100+4, o_irq high one cycle later, ACTIVE=0x80000002.
REQ-032 CMP[1]=0xFFF0 written at slice 0xFFE0, run past wrap -> pending[1] sets at 0xFFF0 within 4 cycles, not earlier, not again after wrap.
REQ-033 Channel 0 and 3 expire, ENABLE=0x9; write PENDING=0x1 -> ACTIVE=0x80000003, o_irq stays high; write 0x8 -> o_irq low.
REQ-034 W1C of bit 2 in exact cycle of channel 2 expiry -> pending[2] remains 1.
REQ-035 PERIODIC_EN: CMP[0]=50, PERIOD[0]=20 -> pending at 50, clear, pending again at 70, CMP[0] reads 90; without macro, read of word 8 returns 0 and no second expiry.

Source files
------------

// File: rtl/rocketcpu_timer_sched_pkg.sv
// Shared register map, ACTIVE valid-bit position and address decode for the timer scheduler.
// Pure declarations and one combinational helper, so there is no latency and no backpressure.
package rocketcpu_timer_pkg;

  localparam int unsigned REG_TIME       = 0;
  localparam int unsigned REG_PENDING    = 1;
  localparam int unsigned REG_ENABLE     = 2;
  localparam int unsigned REG_ACTIVE     = 3;
  localparam int unsigned REG_CMP_BASE   = 4;
  localparam int unsigned ACTIVE_VLD_BIT = 31;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_TIME,
    SEL_PENDING,
    SEL_ENABLE,
    SEL_ACTIVE,
    SEL_CMP,
    SEL_PERIOD
  } reg_sel_e;

  typedef struct packed {
    reg_sel_e   sel;
    logic [2:0] idx;
  } reg_dec_t;

  // PERIOD[k] sits directly after the CMP bank and exists only when periodic mode is built in.
  function automatic reg_dec_t decode_reg(input logic [4:0] adr, input int unsigned channels,
                                          input bit periodic_en);
    reg_dec_t    d;
    int unsigned a;
    a     = 32'(adr);
    d.sel = SEL_NONE;
    d.idx = '0;
    if (a == REG_TIME) begin
      d.sel = SEL_TIME;
    end else if (a == REG_PENDING) begin
      d.sel = SEL_PENDING;
    end else if (a == REG_ENABLE) begin
      d.sel = SEL_ENABLE;
    end else if (a == REG_ACTIVE) begin
      d.sel = SEL_ACTIVE;
    end else if (a >= REG_CMP_BASE && a < REG_CMP_BASE + channels) begin
      d.sel = SEL_CMP;
      d.idx = 3'(a - REG_CMP_BASE);
    end else if (periodic_en && a >= REG_CMP_BASE + channels &&
                 a < REG_CMP_BASE + 2 * channels) begin
      d.sel = SEL_PERIOD;
      d.idx = 3'(a - REG_CMP_BASE - channels);
    end
    return d;
  endfunction

endpackage

// File: rtl/rocketcpu_timer_sched_if.sv
// Register bus between a host and the timer scheduler: one access per cycle-delayed ack, no stalls.
interface rocketcpu_timer_sched_if;
  logic [4:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic        o_wb_ack;
  logic [31:0] o_wb_rdt;

  modport master (
    output i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
    input  o_wb_ack, o_wb_rdt
  );

  modport slave (
    input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_cyc,
    output o_wb_ack, o_wb_rdt
  );
endinterface

// File: rtl/rocketcpu_timer_cmp.sv
// Wrap-safe "slice has reached compare" test: true when (slice - cmp) mod 2^S lies in the lower half.
// Purely combinational, zero latency, no backpressure.
module rocketcpu_timer_cmp #(
  parameter int S = 16
) (
  input  logic [S-1:0] slice_i,
  input  logic [S-1:0] cmp_i,
  output logic         reached_o
);

  logic [S-1:0] diff;

  assign diff      = slice_i - cmp_i;
  assign reached_o = ~diff[S-1];

endmodule

// File: rtl/rocketcpu_timer_sched.sv
// Timer scheduler: free-running mtime, CHANNELS compare channels scanned one per cycle, W1C pending, level irq.
// Bus ack one cycle after cyc, never stalls; ROCKETCPU_TIMER_SCHED_PERIODIC_EN adds auto-reload PERIOD[k].
module rocketcpu_timer_sched
  import rocketcpu_timer_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DIVIDER  = 0,
  parameter int CHANNELS = 4
) (
  input  logic                   i_wb_clk,
  input  logic                   i_wb_rst,
  rocketcpu_timer_sched_if.slave wb,
  output logic                   o_irq
);

  localparam int S  = WIDTH - DIVIDER;
  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] TIME_ONE = WIDTH'(1);
  localparam logic [PW-1:0]    P_ONE    = PW'(1);
  localparam logic [PW-1:0]    P_LAST   = PW'(CHANNELS - 1);
`ifdef ROCKETCPU_TIMER_SCHED_PERIODIC_EN
  localparam bit PERIODIC = 1'b1;
`else
  localparam bit PERIODIC = 1'b0;
`endif

  logic [WIDTH-1:0]    mtime_q, mtime_d;
  logic [PW-1:0]       p_q, p_d;
  logic [CHANNELS-1:0] pending_q, pending_d;
  logic [CHANNELS-1:0] armed_q, armed_d;
  logic [CHANNELS-1:0] enable_q, enable_d;
  logic [S-1:0]        cmp_q [CHANNELS];
  logic [S-1:0]        cmp_d [CHANNELS];
`ifdef ROCKETCPU_TIMER_SCHED_PERIODIC_EN
  logic [S-1:0]        period_q [CHANNELS];
  logic [S-1:0]        period_d [CHANNELS];
`endif
  logic                ack_q;
  logic [31:0]         rdt_q, rdata;
  logic                irq_q;

  logic                access, wr;
  reg_dec_t            dec;
  logic [S-1:0]        slice, cmp_cur;
  logic                reached, cmp_wr_hit, expire;
  logic [CHANNELS-1:0] act;
  logic [2:0]          active_idx;
  logic                active_vld;
  logic                unused_bits;

  assign access  = wb.i_wb_cyc & ~ack_q;
  assign wr      = access & wb.i_wb_we;
  assign dec     = decode_reg(wb.i_wb_adr, CHANNELS, PERIODIC);
  assign slice   = mtime_q[WIDTH-1:DIVIDER];
  assign cmp_cur = cmp_q[p_q];

  rocketcpu_timer_cmp #(.S(S)) u_cmp (
    .slice_i  (slice),
    .cmp_i    (cmp_cur),
    .reached_o(reached)
  );

  // A CMP write landing on the channel under scan re-arms it and suppresses this cycle's expiry.
  assign cmp_wr_hit = wr && (dec.sel == SEL_CMP) && (dec.idx == 3'(p_q));
  assign expire     = armed_q[p_q] & reached & ~cmp_wr_hit;

  assign act = pending_q & enable_q;

  always_comb begin
    active_idx = '0;
    active_vld = 1'b0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (act[k]) begin
        active_idx = 3'(k);
        active_vld = 1'b1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (dec.sel)
      SEL_TIME:    rdata = 32'(slice);
      SEL_PENDING: rdata = 32'(pending_q);
      SEL_ENABLE:  rdata = 32'(enable_q);
      SEL_ACTIVE: begin
        rdata[ACTIVE_VLD_BIT] = active_vld;
        rdata[2:0]            = active_idx;
      end
      SEL_CMP:     rdata = 32'(cmp_q[dec.idx[PW-1:0]]);
`ifdef ROCKETCPU_TIMER_SCHED_PERIODIC_EN
      SEL_PERIOD:  rdata = 32'(period_q[dec.idx[PW-1:0]]);
`endif
      default:     rdata = '0;
    endcase
  end

  always_comb begin
    mtime_d   = mtime_q + TIME_ONE;
    p_d       = (p_q == P_LAST) ? '0 : p_q + P_ONE;
    pending_d = pending_q;
    armed_d   = armed_q;
    enable_d  = enable_q;
    cmp_d     = cmp_q;
`ifdef ROCKETCPU_TIMER_SCHED_PERIODIC_EN
    period_d  = period_q;
`endif

    if (wr && dec.sel == SEL_PENDING) begin
      pending_d = pending_q & ~wb.i_wb_dat[CHANNELS-1:0];
    end
    if (wr && dec.sel == SEL_ENABLE) begin
      enable_d = wb.i_wb_dat[CHANNELS-1:0];
    end

    // Expiry is applied after the W1C so a same-cycle set wins.
    if (expire) begin
      pending_d[p_q] = 1'b1;
`ifdef ROCKETCPU_TIMER_SCHED_PERIODIC_EN
      if (period_q[p_q] != '0) begin
        cmp_d[p_q] = cmp_q[p_q] + period_q[p_q];
      end else begin
        armed_d[p_q] = 1'b0;
      end
`else
      armed_d[p_q] = 1'b0;
`endif
    end

    if (wr && dec.sel == SEL_CMP) begin
      cmp_d[dec.idx[PW-1:0]]   = wb.i_wb_dat[S-1:0];
      armed_d[dec.idx[PW-1:0]] = 1'b1;
    end
`ifdef ROCKETCPU_TIMER_SCHED_PERIODIC_EN
    if (wr && dec.sel == SEL_PERIOD) begin
      period_d[dec.idx[PW-1:0]] = wb.i_wb_dat[S-1:0];
    end
`endif
  end

  always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
    if (i_wb_rst) begin
      mtime_q   <= '0;
      p_q       <= '0;
      pending_q <= '0;
      armed_q   <= '0;
      enable_q  <= '0;
      for (int k = 0; k < CHANNELS; k++) begin
        cmp_q[k] <= '0;
`ifdef ROCKETCPU_TIMER_SCHED_PERIODIC_EN
        period_q[k] <= '0;
`endif
      end
      ack_q <= 1'b0;
      rdt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      mtime_q   <= mtime_d;
      p_q       <= p_d;
      pending_q <= pending_d;
      armed_q   <= armed_d;
      enable_q  <= enable_d;
      for (int k = 0; k < CHANNELS; k++) begin
        cmp_q[k] <= cmp_d[k];
`ifdef ROCKETCPU_TIMER_SCHED_PERIODIC_EN
        period_q[k] <= period_d[k];
`endif
      end
      ack_q <= access;
      rdt_q <= access ? rdata : '0;
      irq_q <= |act;
    end
  end

  assign wb.o_wb_ack = ack_q;
  assign wb.o_wb_rdt = rdt_q;
  assign o_irq       = irq_q;

  assign unused_bits = ^{wb.i_wb_dat, dec.idx};

endmodule

// File: tb/tb_rocketcpu_timer_sched.sv
// Bench for rocketcpu_timer_sched (WIDTH=16, CHANNELS=4): per-cycle model compare plus directed literal checks.
module tb_rocketcpu_timer_sched;

  localparam int WIDTH = 16;
  localparam int CH    = 4;
  localparam int MASK  = 32'h0000_FFFF;
  localparam int HALF  = 32768;
`ifdef ROCKETCPU_TIMER_SCHED_PERIODIC_EN
  localparam bit PERIODIC = 1'b1;
`else
  localparam bit PERIODIC = 1'b0;
`endif

  logic clk;
  logic rst;
  logic irq;
  int   n_tests = 0;
  int   n_fail  = 0;

  rocketcpu_timer_sched_if wb ();

  rocketcpu_timer_sched #(.WIDTH(WIDTH), .DIVIDER(0), .CHANNELS(CH)) dut (
    .i_wb_clk(clk),
    .i_wb_rst(rst),
    .wb      (wb),
    .o_irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model: timer value, per-channel deadline/armed/period, pending and enable masks.
  int          m_mtime = 0;
  int          m_cmp    [CH];
  int          m_period [CH];
  bit [3:0]    m_armed   = '0;
  bit [3:0]    m_pending = '0;
  bit [3:0]    m_enable  = '0;
  bit          m_ack = 1'b0;
  bit          m_irq = 1'b0;
  logic [31:0] m_rdt = '0;

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] v;
    v = '0;
    if (a == 0) v = 32'(m_mtime);
    else if (a == 1) v = 32'(m_pending);
    else if (a == 2) v = 32'(m_enable);
    else if (a == 3) begin
      for (int k = CH - 1; k >= 0; k--)
        if (m_pending[k] && m_enable[k]) v = 32'h8000_0000 | 32'(k);
    end else if (a >= 4 && a < 4 + CH) v = 32'(m_cmp[a-4]);
    else if (PERIODIC && a >= 4 + CH && a < 4 + 2 * CH) v = 32'(m_period[a-4-CH]);
    return v;
  endfunction

  always @(posedge clk) begin : model
    int          a, k;
    bit          acc, wr;
    logic [31:0] rv;
    bit [3:0]    setm;
    if (rst) begin
      m_mtime = 0; m_armed = '0; m_pending = '0; m_enable = '0;
      m_ack = 1'b0; m_irq = 1'b0; m_rdt = '0;
      for (int i = 0; i < CH; i++) begin m_cmp[i] = 0; m_period[i] = 0; end
    end else begin
      a    = int'(wb.i_wb_adr);
      acc  = wb.i_wb_cyc && !m_ack;
      wr   = acc && wb.i_wb_we;
      rv   = model_read(a);
      k    = m_mtime % CH;
      setm = '0;
      if (m_armed[k] && !(wr && a == 4 + k) && (((m_mtime - m_cmp[k]) & MASK) < HALF)) begin
        setm[k] = 1'b1;
        if (PERIODIC && m_period[k] != 0) m_cmp[k] = (m_cmp[k] + m_period[k]) & MASK;
        else m_armed[k] = 1'b0;
      end
      m_irq = (m_pending & m_enable) != 0;
      if (wr) begin
        if (a == 1) m_pending = m_pending & ~wb.i_wb_dat[3:0];
        else if (a == 2) m_enable = wb.i_wb_dat[3:0];
        else if (a >= 4 && a < 4 + CH) begin
          m_cmp[a-4]   = int'(wb.i_wb_dat) & MASK;
          m_armed[a-4] = 1'b1;
        end else if (PERIODIC && a >= 4 + CH && a < 4 + 2 * CH)
          m_period[a-4-CH] = int'(wb.i_wb_dat) & MASK;
      end
      m_pending = m_pending | setm;
      m_mtime   = (m_mtime + 1) & MASK;
      m_ack     = acc;
      m_rdt     = acc ? rv : '0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("cyc_ack", 32'(wb.o_wb_ack), 32'(m_ack));
      check("cyc_rdt", wb.o_wb_rdt, m_rdt);
      check("cyc_irq", 32'(irq), 32'(m_irq));
    end
  end

  // Bus tasks are entered on a falling edge and return on a falling edge with the bus idle.
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    wb.i_wb_cyc = 1'b1; wb.i_wb_we = 1'b1; wb.i_wb_adr = a; wb.i_wb_dat = d;
    @(negedge clk);
    wb.i_wb_cyc = 1'b0; wb.i_wb_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    wb.i_wb_cyc = 1'b1; wb.i_wb_we = 1'b0; wb.i_wb_adr = a;
    @(negedge clk);
    d = wb.o_wb_rdt;
    wb.i_wb_cyc = 1'b0;
    @(negedge clk);
    check(name, d, exp);
  endtask

  task automatic wait_until(input int t);
    int n;
    n = 0;
    while (m_mtime < t && n < 70000) begin
      @(negedge clk);
      n++;
    end
    if (m_mtime < t) check("wait_timeout", 32'(m_mtime), 32'(t));
  endtask

  task automatic do_reset();
    wb.i_wb_cyc = 1'b0; wb.i_wb_we = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    wb.i_wb_cyc = 1'b0; wb.i_wb_we = 1'b0; wb.i_wb_adr = '0; wb.i_wb_dat = '0;
    for (int i = 0; i < CH; i++) begin m_cmp[i] = 0; m_period[i] = 0; end
    repeat (3) @(negedge clk);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(wb.o_wb_ack), 32'd0);
    check("rst_rdt", wb.o_wb_rdt, 32'd0);
    rst = 1'b0;

    // Reset state of every register class.
    read_check("rst_time", 5'd0, 32'd0);
    read_check("rst_pending", 5'd1, 32'd0);
    read_check("rst_enable", 5'd2, 32'd0);
    read_check("rst_active", 5'd3, 32'd0);
    read_check("rst_cmp2", 5'd6, 32'd0);
    read_check("rst_word8", 5'd8, 32'd0);

    // Single deadline on channel 2.
    bus_write(5'd6, 32'd100);
    bus_write(5'd2, 32'd4);
    read_check("cmp2_rd", 5'd6, 32'd100);
    wait_until(103);
    check("c2_irq_early", 32'(irq), 32'd0);
    @(negedge clk);
    check("c2_irq_104", 32'(irq), 32'd1);
    read_check("c2_pending", 5'd1, 32'h4);
    read_check("c2_active", 5'd3, 32'h8000_0002);

    // Two channels, W1C one at a time.
    bus_write(5'd4, 32'd140);
    bus_write(5'd7, 32'd140);
    bus_write(5'd2, 32'h9);
    bus_write(5'd1, 32'h4);
    bus_write(5'd6, 32'd200);
    wait_until(150);
    read_check("c03_pending", 5'd1, 32'h9);
    read_check("c03_active0", 5'd3, 32'h8000_0000);
    bus_write(5'd1, 32'h1);
    read_check("c03_active3", 5'd3, 32'h8000_0003);
    check("c03_irq_hi", 32'(irq), 32'd1);
    bus_write(5'd1, 32'h8);
    check("c03_irq_lo", 32'(irq), 32'd0);

    // W1C of bit 2 landing in the very cycle channel 2 expires.
    wait_until(202);
    check("sync_202", 32'(m_mtime), 32'd202);
    bus_write(5'd1, 32'h4);
    read_check("setwins_pend", 5'd1, 32'h4);

    // Reset in the middle of a read: no ack for it.
    wb.i_wb_cyc = 1'b1; wb.i_wb_we = 1'b0; wb.i_wb_adr = 5'd0;
    #2 rst = 1'b1;
    @(negedge clk);
    check("abort_ack", 32'(wb.o_wb_ack), 32'd0);
    wb.i_wb_cyc = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ack2", 32'(wb.o_wb_ack), 32'd0);

    // Periodic reload (or one-shot when the feature is absent).
    bus_write(5'd4, 32'd50);
    bus_write(5'd8, 32'd20);
    bus_write(5'd2, 32'h1);
    wait_until(53);
    check("per_irq_53", 32'(irq), 32'd0);
    @(negedge clk);
    check("per_irq_54", 32'(irq), 32'd1);
    read_check("per_pend1", 5'd1, 32'h1);
    bus_write(5'd1, 32'h1);
    read_check("per_cmp_a", 5'd4, PERIODIC ? 32'd70 : 32'd50);
    wait_until(73);
    check("per_irq_73", 32'(irq), 32'd0);
    @(negedge clk);
    check("per_irq_74", 32'(irq), PERIODIC ? 32'd1 : 32'd0);
    read_check("per_cmp_b", 5'd4, PERIODIC ? 32'd90 : 32'd50);
    read_check("per_word8", 5'd8, PERIODIC ? 32'd20 : 32'd0);
    read_check("per_pend2", 5'd1, PERIODIC ? 32'h1 : 32'h0);

    // Deadline just before timer wrap.
    do_reset();
    bus_write(5'd2, 32'h2);
    wait_until(32'hFFE0);
    bus_write(5'd5, 32'hFFF0);
    wait_until(32'hFFF2);
    check("wrap_irq_early", 32'(irq), 32'd0);
    @(negedge clk);
    check("wrap_irq_set", 32'(irq), 32'd1);
    read_check("wrap_pending", 5'd1, 32'h2);
    bus_write(5'd1, 32'h2);
    repeat (40) @(negedge clk);
    read_check("wrap_no_refire", 5'd1, 32'h0);
    check("wrap_irq_lo", 32'(irq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
